fll_freq_monitor: RTL and testbench
===================================

# fll_freq_monitor

Multi-channel frequency-lock monitor for the S3 FLL/I2S fabric. It counts rising edges of one master bit clock and NUM_CH local bit clocks over a programmable window of master edges. Per channel, it compares the signed count difference against a deadband and raises speedup/slowdown interrupts toward FB_msg_out. It replaces the single-pair comparator inside the FLL IP and adds per-channel deadband evaluation, a pulse or level interrupt mode, signed difference readback and overflow flags.

## Interface
- NUM_CH, 2, number of local bit clocks monitored (1..4)
- CNT_W, 16, edge-counter width; the difference is CNT_W+1 bits, signed
- SYNC_STAGES, 2, synchroniser depth on the asynchronous clock inputs (≥2)

Ports:
- CLK_IP_i  in  1  monitor clock; must be ≥4× the fastest bit clock
- RST_IP_N_i  in  1  reset, synchronous, active-low
- bitclk_master_i  in  1  master bit clock, asynchronous
- bitclk_local_i  in  NUM_CH  local bit clocks, asynchronous
- enable_i  in  1  run measurement
- window_i  in  CNT_W  master rising edges per window; 0 means disabled
- deadband_i  in  CNT_W  unsigned tolerance on |diff|
- mode_i  in  1  0 = one-cycle pulse interrupts, 1 = sticky level interrupts
- int_clr_i  in  NUM_CH  clears level interrupts, one bit per channel
- Interrupt_speedup_o  out  NUM_CH  local clock slow
- Interrupt_slowdown_o  out  NUM_CH  local clock fast
- diff_o  out  NUM_CH*(CNT_W+1)  last signed difference (local − master); channel k is at [k*(CNT_W+1) +: CNT_W+1]
- win_done_o  out  1  one-cycle pulse per completed window
- overflow_o  out  NUM_CH  sticky; set when a local counter saturated

## Operation
- Input conditioning:
  - Each clock input passes through SYNC_STAGES flops, then a one-flop rising-edge detector.
  - This produces a single-cycle edge strobe.
- State machine: IDLE, ARM, MEASURE, EVAL.
  - IDLE → ARM when enable_i=1 and window_i≠0.
  - ARM: on the first master edge, latch window_i and deadband_i, zero all counters, go to MEASURE. Local edges in that cycle are counted.
  - MEASURE:
    - m_cnt increments on each master edge.
    - l_cnt[k] increments on each local edge, saturating at 2^CNT_W−1.
    - Saturation sets overflow_o[k].
    - When a master edge makes m_cnt equal the latched window, go to EVAL. Local edges in that cycle are counted.
  - EVAL (one cycle), per channel:
    - diff = l_cnt − m_cnt, sign-extended to CNT_W+2 for comparison.
    - diff < −deadband → speedup event.
    - diff > deadband → slowdown event.
    - Otherwise no event.
    - Counters reload to 0, plus 1 for any edge in the EVAL cycle.
    - Window and deadband are re-latched.
    - Next state is MEASURE if enable_i=1, else IDLE.
- enable_i=0 in ARM or MEASURE: go to IDLE next cycle. No evaluation happens, and diff_o and the interrupts hold their values.
- window_i and deadband_i changes take effect only at the next latch point (ARM or EVAL).
- Pulse mode: an interrupt bit is high for exactly one cycle per event.
- Level mode:
  - An event sets its bit and clears the opposite bit of the same channel.
  - int_clr_i[k] clears both bits of channel k.
  - If an event and a clear occur in the same cycle, the event wins.
- Changing mode_i clears all interrupt bits.
- overflow_o[k] clears only on reset or on int_clr_i[k] while in IDLE.
- Speedup and slowdown are never high together on one channel.

## Timing
- Reset: all outputs are 0, state is IDLE, counters are 0.
- Reset asserted mid-window aborts immediately. No win_done_o pulse and no interrupt is produced.
- Pin edge to edge strobe: SYNC_STAGES+1 cycles.
- Outputs are registered:
  - diff_o, the interrupts and win_done_o update on the cycle after EVAL, all together.
  - Latency from the window-closing master strobe to the outputs is 2 cycles.
- Windows are contiguous. No master or local edge is dropped between consecutive windows.
- Phase quantisation is ±1 count, so deadband 0 with equal clocks may report ±1.

## Test plan
- Equal clocks:
  - Stimulus: master and local[0] at period 8 CLK, window=16, deadband=1, pulse mode.
  - Required: win_done_o every 128 cycles, diff_o[0] ∈ {−1,0,1}, no interrupts.
- Local slow:
  - Stimulus: master period 8, local[1] period 10, window=40, deadband=2.
  - Required: diff_o[1]=−8 and Interrupt_speedup_o[1] pulses one cycle, aligned with win_done_o.
- Local fast, level mode:
  - Stimulus: master period 12, local[0] period 10, window=30, deadband=2.
  - Required: diff=+6, Interrupt_slowdown_o[0] stays high.
  - int_clr_i[0] drops it; an int_clr_i[0] coinciding with the next event leaves it set.
- Abort:
  - Stimulus: deassert enable_i at master edge 10 of window 40.
  - Required: IDLE, no win_done_o, diff_o unchanged.
  - Re-enable: next window starts at the first master edge.
- Overflow:
  - Stimulus: CNT_W=8, master period 32, local period 8, window=100.
  - Required: l_cnt saturates at 255, overflow_o set, slowdown event, diff_o=155.
- Reset mid-window:
  - Stimulus: drive RST_IP_N_i low for 1 cycle during MEASURE.
  - Required: all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/fll_freq_monitor.sv
// Multi-channel frequency-lock monitor: counts master and local bit-clock edges over a
// window of master edges and flags local clocks that run outside a signed deadband.
module fll_freq_monitor #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK_IP_i,
  input  logic                          RST_IP_N_i,
  input  logic                          bitclk_master_i,
  input  logic [NUM_CH-1:0]             bitclk_local_i,
  input  logic                          enable_i,
  input  logic [CNT_W-1:0]              window_i,
  input  logic [CNT_W-1:0]              deadband_i,
  input  logic                          mode_i,
  input  logic [NUM_CH-1:0]             int_clr_i,
  output logic [NUM_CH-1:0]             Interrupt_speedup_o,
  output logic [NUM_CH-1:0]             Interrupt_slowdown_o,
  output logic [NUM_CH*(CNT_W+1)-1:0]   diff_o,
  output logic                          win_done_o,
  output logic [NUM_CH-1:0]             overflow_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int NIN = NUM_CH + 1;
  localparam int DW  = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_EVAL    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Bit 0 is the master clock, bits 1..NUM_CH are the local clocks.
  logic [NIN-1:0]    sync_q [SYNC_STAGES];
  logic [NIN-1:0]    edge_q;
  logic [NIN-1:0]    stb;
  logic              m_stb;
  logic [NUM_CH-1:0] l_stb;

  logic [CNT_W-1:0]  m_cnt_q;
  logic [CNT_W-1:0]  m_cnt_inc;
  logic [CNT_W-1:0]  l_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  win_q;
  logic [CNT_W-1:0]  db_q;
  logic [NUM_CH-1:0] ovf_q;

  logic [DW-1:0]             diff_c [NUM_CH];
  logic signed [CNT_W+1:0]   diff_x [NUM_CH];
  logic signed [CNT_W+1:0]   db_pos;
  logic signed [CNT_W+1:0]   db_neg;
  logic [NUM_CH-1:0]         spd_evt;
  logic [NUM_CH-1:0]         slw_evt;
  logic                      eval;

  logic [NUM_CH-1:0]         spd_q;
  logic [NUM_CH-1:0]         slw_q;
  logic [NUM_CH*DW-1:0]      diff_q;
  logic                      done_q;
  logic                      mode_q;

  always_ff @(posedge CLK_IP_i) begin
    if (!RST_IP_N_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= {bitclk_local_i, bitclk_master_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign stb       = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign m_stb     = stb[0];
  assign l_stb     = stb[NIN-1:1];
  assign m_cnt_inc = m_cnt_q + 1'b1;
  assign eval      = (state_q == S_EVAL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i && (window_i != '0)) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable_i || (window_i == '0)) state_d = S_IDLE;
        else if (m_stb)                    state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (!enable_i)                           state_d = S_IDLE;
        else if (m_stb && (m_cnt_inc == win_q))  state_d = S_EVAL;
      end
      S_EVAL: begin
        state_d = (enable_i && (window_i != '0)) ? S_MEASURE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The master edge that opens a window is its boundary, so the master count starts at 0
  // while local edges in that same cycle already belong to the new window.
  always_ff @(posedge CLK_IP_i) begin
    if (!RST_IP_N_i) begin
      state_q <= S_IDLE;
      m_cnt_q <= '0;
      win_q   <= '0;
      db_q    <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) l_cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          ovf_q <= ovf_q & ~int_clr_i;
        end
        S_ARM: begin
          if (state_d == S_MEASURE) begin
            win_q   <= window_i;
            db_q    <= deadband_i;
            m_cnt_q <= '0;
            for (int k = 0; k < NUM_CH; k++) l_cnt_q[k] <= CNT_W'(l_stb[k]);
          end
        end
        S_MEASURE: begin
          m_cnt_q <= m_cnt_q + CNT_W'(m_stb);
          for (int k = 0; k < NUM_CH; k++) begin
            if (l_stb[k]) begin
              if (l_cnt_q[k] != CNT_MAX) l_cnt_q[k] <= l_cnt_q[k] + 1'b1;
              if (l_cnt_q[k] >= CNT_MAX - 1'b1) ovf_q[k] <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          win_q   <= window_i;
          db_q    <= deadband_i;
          m_cnt_q <= CNT_W'(m_stb);
          for (int k = 0; k < NUM_CH; k++) l_cnt_q[k] <= CNT_W'(l_stb[k]);
        end
        default: ;
      endcase
    end
  end

  // One extra sign bit keeps -deadband representable for the full counter range.
  always_comb begin
    spd_evt = '0;
    slw_evt = '0;
    db_pos  = $signed({2'b00, db_q});
    db_neg  = -db_pos;
    for (int k = 0; k < NUM_CH; k++) begin
      diff_c[k]  = {1'b0, l_cnt_q[k]} - {1'b0, m_cnt_q};
      diff_x[k]  = $signed({diff_c[k][DW-1], diff_c[k]});
      spd_evt[k] = (diff_x[k] < db_neg);
      slw_evt[k] = (diff_x[k] > db_pos);
    end
  end

  always_ff @(posedge CLK_IP_i) begin
    if (!RST_IP_N_i) begin
      spd_q  <= '0;
      slw_q  <= '0;
      diff_q <= '0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      done_q <= eval;
      mode_q <= mode_i;
      for (int k = 0; k < NUM_CH; k++) begin
        if (eval) diff_q[k*DW +: DW] <= diff_c[k];
        if (mode_i != mode_q) begin
          spd_q[k] <= 1'b0;
          slw_q[k] <= 1'b0;
        end else if (!mode_q) begin
          spd_q[k] <= eval & spd_evt[k];
          slw_q[k] <= eval & slw_evt[k];
        end else if (eval && spd_evt[k]) begin
          spd_q[k] <= 1'b1;
          slw_q[k] <= 1'b0;
        end else if (eval && slw_evt[k]) begin
          spd_q[k] <= 1'b0;
          slw_q[k] <= 1'b1;
        end else if (int_clr_i[k]) begin
          spd_q[k] <= 1'b0;
          slw_q[k] <= 1'b0;
        end
      end
    end
  end

  assign Interrupt_speedup_o  = spd_q;
  assign Interrupt_slowdown_o = slw_q;
  assign diff_o               = diff_q;
  assign win_done_o           = done_q;
  assign overflow_o           = ovf_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_fll_freq_monitor.sv
// Directed bench for fll_freq_monitor: bit clocks are synthesised from the monitor clock
// with chosen periods/phases so every window count is known exactly.
module tb_fll_freq_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        bm;
  logic [1:0]  bl;
  logic        en;
  logic [15:0] win;
  logic [15:0] db;
  logic        mode;
  logic [1:0]  clr;
  logic [1:0]  spd;
  logic [1:0]  slw;
  logic [33:0] diff;
  logic        done;
  logic [1:0]  ovf;
  logic [1:0]  st;

  logic        bm2;
  logic [0:0]  bl2;
  logic        en2;
  logic [7:0]  win2;
  logic [7:0]  db2;
  logic        mode2;
  logic [0:0]  clr2;
  logic [0:0]  spd2;
  logic [0:0]  slw2;
  logic [8:0]  diff2;
  logic        done2;
  logic [0:0]  ovf2;
  logic [1:0]  st2;

  fll_freq_monitor #(.NUM_CH(2), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .CLK_IP_i(clk), .RST_IP_N_i(rst_n), .bitclk_master_i(bm), .bitclk_local_i(bl),
    .enable_i(en), .window_i(win), .deadband_i(db), .mode_i(mode), .int_clr_i(clr),
    .Interrupt_speedup_o(spd), .Interrupt_slowdown_o(slw), .diff_o(diff),
    .win_done_o(done), .overflow_o(ovf), .dbg_state_o(st)
  );

  fll_freq_monitor #(.NUM_CH(1), .CNT_W(8), .SYNC_STAGES(2)) dut2 (
    .CLK_IP_i(clk), .RST_IP_N_i(rst_n), .bitclk_master_i(bm2), .bitclk_local_i(bl2),
    .enable_i(en2), .window_i(win2), .deadband_i(db2), .mode_i(mode2), .int_clr_i(clr2),
    .Interrupt_speedup_o(spd2), .Interrupt_slowdown_o(slw2), .diff_o(diff2),
    .win_done_o(done2), .overflow_o(ovf2), .dbg_state_o(st2)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];

  // Bit-clock generator: rising edge where (cyc + off) % per == 0.
  int cyc = 0;
  int m_per = 8, m_off = 0;
  int l_per [2] = '{8, 8};
  int l_off [2] = '{0, 0};
  int m2_per = 0, l2_per = 0;
  int m_rise = 0;
  int int_seen = 0;
  int done_seen = 0;
  logic bm_prev = 1'b0;

  function automatic logic gen(input int c, input int per, input int off);
    if (per == 0) return 1'b0;
    return ((c + off) % per) < (per / 2);
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    bm    = gen(cyc, m_per, m_off);
    bl[0] = gen(cyc, l_per[0], l_off[0]);
    bl[1] = gen(cyc, l_per[1], l_off[1]);
    bm2   = gen(cyc, m2_per, 0);
    bl2   = gen(cyc, l2_per, 0);
    if (bm && !bm_prev) m_rise = m_rise + 1;
    bm_prev = bm;
    if ((spd | slw) != 2'b00) int_seen = int_seen + 1;
    if (done === 1'b1) done_seen = done_seen + 1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input bit sel, input int budget, input string tag, output int waited);
    waited = 0;
    while (((sel ? done2 : done) !== 1'b1) && (waited < budget)) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, longint'(sel ? done2 : done), 1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int waited;
    waited = 0;
    while ((st !== s) && (waited < budget)) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, longint'(st), longint'(s));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    longint d0;
    logic [33:0] exp_abort;
    logic [16:0] exp_e;

    rst_n = 1'b0; en = 1'b0; win = '0; db = '0; mode = 1'b0; clr = '0;
    en2 = 1'b0; win2 = '0; db2 = '0; mode2 = 1'b0; clr2 = '0;
    bm = 1'b0; bl = '0; bm2 = 1'b0; bl2 = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    chk("rst_state", st, 0);
    chk("rst_diff", diff, 0);
    chk("rst_int", {spd, slw}, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst2_diff", diff2, 0);

    // Equal clocks, pulse mode.
    win = 16; db = 1; mode = 1'b0;
    int_seen = 0;
    en = 1'b1;
    wait_done(0, 400, "eq_done0", w);
    d0 = $signed(diff[16:0]);
    chk("eq_diff0_range", longint'(d0 >= -1 && d0 <= 1), 1);
    for (int i = 0; i < 2; i++) begin
      tick(1);
      wait_done(0, 200, "eq_done", w);
      chk("eq_period", w + 1, 128);
      d0 = $signed(diff[16:0]);
      chk("eq_diff0_range", longint'(d0 >= -1 && d0 <= 1), 1);
    end
    chk("eq_no_int", int_seen, 0);
    en = 1'b0;
    tick(3);
    chk("eq_idle", st, 0);

    // Local[1] slow: 320 cycles hold 32 local edges against 40 master edges.
    l_per[1] = 10; l_off[1] = 3;
    win = 40; db = 2;
    exp_q.push_back(17'h1FFF8);
    exp_q.push_back(17'h1FFF8);
    tick(20);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_done(0, 800, "slow_done", w);
      exp_e = exp_q.pop_front();
      chk("slow_diff1", diff[33:17], exp_e);
      chk("slow_spd1", spd[1], 1);
      chk("slow_slw1", slw[1], 0);
      tick(1);
      chk("slow_spd1_pulse", spd[1], 0);
    end

    // Abort at master edge 10 of the third window.
    base = m_rise;
    w = 0;
    while ((m_rise - base < 10) && (w < 200)) begin
      tick(1);
      w++;
    end
    chk("abort_edges", longint'(m_rise - base >= 10), 1);
    en = 1'b0;
    done_seen = 0;
    tick(3);
    chk("abort_state", st, 0);
    tick(400);
    chk("abort_nodone", done_seen, 0);
    exp_abort = {17'h1FFF8, 17'h00000};
    chk("abort_diff", diff, exp_abort);
    en = 1'b1;
    wait_done(0, 400, "rearm_done", w);
    chk("rearm_lat", longint'(w >= 320 && w <= 340), 1);
    chk("rearm_diff1", diff[33:17], 17'h1FFF8);
    en = 1'b0;
    tick(3);

    // Local[0] fast, level mode: 36 local edges against 30 master edges.
    m_per = 12; l_per[0] = 10; l_off[0] = 1;
    win = 30; db = 2; mode = 1'b1;
    tick(20);
    en = 1'b1;
    wait_done(0, 900, "lvl_done", w);
    chk("lvl_diff0", diff[16:0], 6);
    chk("lvl_slw0", slw[0], 1);
    chk("lvl_spd0", spd[0], 0);
    tick(20);
    chk("lvl_hold", slw[0], 1);
    clr = 2'b01;
    tick(1);
    chk("lvl_clr", slw[0], 0);
    clr = 2'b00;
    wait_state(2'd3, 500, "lvl_eval");
    clr = 2'b01;
    tick(1);
    clr = 2'b00;
    chk("lvl_done2", done, 1);
    chk("lvl_evt_wins", slw[0], 1);
    chk("lvl_diff0_2", diff[16:0], 6);
    tick(5);
    mode = 1'b0;
    tick(1);
    chk("mode_clr", {spd, slw}, 0);
    chk("main_ovf", ovf, 0);
    en = 1'b0;
    tick(3);

    // Reset during MEASURE.
    en = 1'b1;
    tick(100);
    chk("pre_rst_state", st, 2);
    rst_n = 1'b0;
    en = 1'b0;
    tick(1);
    chk("rst_mid_state", st, 0);
    chk("rst_mid_diff", diff, 0);
    chk("rst_mid_int", {spd, slw}, 0);
    chk("rst_mid_done", done, 0);
    rst_n = 1'b1;
    done_seen = 0;
    tick(400);
    chk("rst_mid_nodone", done_seen, 0);

    // Saturation on the 8-bit instance: 400 local edges clip at 255 vs 100 master edges.
    m2_per = 32; l2_per = 8;
    win2 = 100; db2 = 2; mode2 = 1'b0;
    tick(40);
    en2 = 1'b1;
    wait_done(1, 3600, "ovf_done", w);
    chk("ovf_diff", diff2, 155);
    chk("ovf_flag", ovf2, 1);
    chk("ovf_slw", slw2, 1);
    chk("ovf_spd", spd2, 0);
    en2 = 1'b0;
    tick(3);
    chk("ovf_sticky", ovf2, 1);
    clr2 = 1'b1;
    tick(1);
    clr2 = 1'b0;
    chk("ovf_clr", ovf2, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
